rgb_line_buffer_feeder: RTL and testbench
=========================================

RGB_LINE_BUFFER_FEEDER -- requirements
Module: rgb_line_buffer_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per colour sample.
REQ-002 Parameter IMG_WIDTH, default 16, pixels per row (>=3).
REQ-003 Parameter IMG_HEIGHT, default 16, rows per frame (>=3).
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pix_valid  input  1  upstream pixel present.
REQ-007 pix_ready  output  1  block can accept a pixel.
REQ-008 pix_r, pix_g, pix_b  input  DATA_WIDTH each  raster-order pixel samples.
REQ-009 col_valid  output  1  input_col_* hold a new 3-row column this cycle.
REQ-010 input_col_r, input_col_g, input_col_b  output  3*DATA_WIDTH each  column per channel; bits [DW-1:0] = row y-2, [2DW-1:DW] = row y-1, [3DW-1:2DW] = row y.
REQ-011 window_done  output  1  emitted column completes a full 3x3 window.
REQ-012 line_end  output  1  emitted column is last of its row.
REQ-013 frame_done  output  1  emitted column is last of the frame.

Function
REQ-014 Pixel accepted on a cycle with pix_valid && pix_ready && !rst; no other cycle alters counters, line buffers or state.
REQ-015 Counters x_cnt (0..IMG_WIDTH-1) and y_cnt (0..IMG_HEIGHT-1), width $clog2 of the bound; x_cnt increments per accept, wraps to 0 at IMG_WIDTH-1 and increments y_cnt.
REQ-016 Per channel, two line buffers of IMG_WIDTH entries: LB0 = row y-1, LB1 = row y-2.
REQ-017 On accept at x: read LB0[x], LB1[x]; write LB1[x] <= LB0[x], LB0[x] <= pixel, same cycle.
REQ-018 FSM states IDLE, FILL, STREAM, DONE; pix_ready = 1 in IDLE, FILL, STREAM; 0 in DONE.
REQ-019 IDLE -> FILL on first accept (pixel x=0,y=0); FILL -> STREAM on accept of x=IMG_WIDTH-1, y=1.
REQ-020 STREAM -> DONE on accept of x=IMG_WIDTH-1, y=IMG_HEIGHT-1; counters return to 0 on that accept.
REQ-021 DONE -> IDLE unconditionally after one cycle.
REQ-022 Accepts with y_cnt <= 1 produce no column (col_valid stays 0).
REQ-023 Accepts with y_cnt >= 2: one cycle later col_valid=1 and input_col_* = {pixel, LB0[x], LB1[x]} (registered, latency 1).
REQ-024 window_done = 1 with that column iff x >= 2; line_end = 1 iff x = IMG_WIDTH-1; frame_done = 1 iff additionally y = IMG_HEIGHT-1; all three are 0 whenever col_valid = 0.
REQ-025 Cycles without accept: col_valid, window_done, line_end and frame_done = 0; input_col_* hold last value.
REQ-026 Channels share counters/FSM; r, g, b paths bit-identical and cycle-aligned.
REQ-027 No arithmetic on samples; values pass unmodified, no truncation or sign extension.

Reset
REQ-028 With rst=1 at a clock edge: state <= IDLE, x_cnt=y_cnt=0, col_valid, window_done, line_end, frame_done = 0, input_col_* = 0; pix_ready reads 1 after reset.
REQ-029 Line buffer contents not cleared by reset; the FILL phase overwrites them before use.
REQ-030 Reset mid-frame discards the partial frame; the next accepted pixel is treated as x=0, y=0.
REQ-031 rst has priority over a simultaneous pix_valid; that pixel is not accepted.

Verification (DW=8, W=4, H=4; r=4y+x, g=r+64, b=r+128)
REQ-032 Reset -> all outputs 0, pix_ready=1, state IDLE.
REQ-033 Stream pixels 0..7 continuously -> col_valid never 1; state STREAM after pixel 7.
REQ-034 Pixel 8 -> next cycle col_valid=1, input_col_r={8,4,0}, input_col_g={72,68,64}, window_done=0. Pixel 10 -> input_col_r={10,6,2}, window_done=1.
REQ-035 Pixel 15 -> input_col_r={15,11,7}, window_done=line_end=frame_done=1. Next cycle pix_ready=0 (DONE). Following cycle pix_ready=1 (IDLE).
REQ-036 Toggle pix_valid 1/0 through row 2 -> col_valid only on cycles after accepts; input_col_* hold value between them. Column values match REQ-034.
REQ-037 rst at pixel 9 of frame 1, then new full frame -> no column until its pixel 8; columns match REQ-034.

Source files
------------

// File: rtl/rgb_line_buffer_feeder.sv
// Raster-order RGB pixel feeder: two line buffers per channel turn a pixel
// stream into registered 3-row columns for a downstream 3x3 window engine.
module rgb_line_buffer_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [DATA_WIDTH-1:0]   pix_r,
  input  logic [DATA_WIDTH-1:0]   pix_g,
  input  logic [DATA_WIDTH-1:0]   pix_b,
  output logic                    col_valid,
  output logic [3*DATA_WIDTH-1:0] input_col_r,
  output logic [3*DATA_WIDTH-1:0] input_col_g,
  output logic [3*DATA_WIDTH-1:0] input_col_b,
  output logic                    window_done,
  output logic                    line_end,
  output logic                    frame_done
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int CW = 3 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] g;
    logic [DATA_WIDTH-1:0] b;
  } rgb_t;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // lb0 holds row y-1, lb1 holds row y-2, both indexed by column.
  rgb_t lb0_q [IMG_WIDTH];
  rgb_t lb1_q [IMG_WIDTH];

  rgb_t          pix_in, above1, above2;
  logic          accept, last_col, last_row, emit;

  logic          col_valid_q, window_done_q, line_end_q, frame_done_q;
  logic [CW-1:0] col_r_q, col_g_q, col_b_q;

  assign pix_ready = (state_q != DONE);
  assign accept    = pix_valid && pix_ready && !rst;
  assign last_col  = (x_q == XW'(IMG_WIDTH - 1));
  assign last_row  = (y_q == YW'(IMG_HEIGHT - 1));
  assign emit      = accept && (y_q >= YW'(2));

  assign pix_in = '{r: pix_r, g: pix_g, b: pix_b};
  assign above1 = lb0_q[x_q];
  assign above2 = lb1_q[x_q];

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;

    if (accept) begin
      if (last_col) begin
        x_d = '0;
        y_d = last_row ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    unique case (state_q)
      IDLE:    if (accept) state_d = FILL;
      FILL:    if (accept && last_col && y_q == YW'(1)) state_d = STREAM;
      STREAM:  if (accept && last_col && last_row) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      col_valid_q   <= 1'b0;
      window_done_q <= 1'b0;
      line_end_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      col_r_q       <= '0;
      col_g_q       <= '0;
      col_b_q       <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      col_valid_q   <= emit;
      window_done_q <= emit && (x_q >= XW'(2));
      line_end_q    <= emit && last_col;
      frame_done_q  <= emit && last_col && last_row;
      if (emit) begin
        col_r_q <= {pix_in.r, above1.r, above2.r};
        col_g_q <= {pix_in.g, above1.g, above2.g};
        col_b_q <= {pix_in.b, above1.b, above2.b};
      end
    end
  end

  // NOTE: line buffers are deliberately not reset; rows 0 and 1 of every
  // frame overwrite them before any column reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[x_q] <= lb0_q[x_q];
      lb0_q[x_q] <= pix_in;
    end
  end

  assign col_valid   = col_valid_q;
  assign window_done = window_done_q;
  assign line_end    = line_end_q;
  assign frame_done  = frame_done_q;
  assign input_col_r = col_r_q;
  assign input_col_g = col_g_q;
  assign input_col_b = col_b_q;

endmodule

// File: tb/tb_rgb_line_buffer_feeder.sv
// Directed bench for rgb_line_buffer_feeder on a 4x4 frame with
// r = 4y+x, g = r+64, b = r+128.
module tb_rgb_line_buffer_feeder;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] pix_r, pix_g, pix_b;
  logic          col_valid;
  logic [3*DW-1:0] input_col_r, input_col_g, input_col_b;
  logic          window_done, line_end, frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  rgb_line_buffer_feeder #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .col_valid  (col_valid),
    .input_col_r(input_col_r),
    .input_col_g(input_col_g),
    .input_col_b(input_col_b),
    .window_done(window_done),
    .line_end   (line_end),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Column for pixel index n of the 4x4 frame: {row y, row y-1, row y-2}.
  function automatic logic [31:0] exp_col(input int n, input int off);
    logic [7:0] top, mid, bot;
    top = 8'(n + off);
    mid = 8'(n - 4 + off);
    bot = 8'(n - 8 + off);
    return {8'h00, top, mid, bot};
  endfunction

  task automatic set_pix(input int n);
    pix_r = 8'(n);
    pix_g = 8'(n + 64);
    pix_b = 8'(n + 128);
  endtask

  // One full frame; with toggle set, row 2 alternates accept / idle cycles.
  task automatic run_frame(input bit toggle);
    for (int n = 0; n < W * H; n++) begin
      set_pix(n);
      pix_valid = 1'b1;
      @(posedge clk); #1;
      if (n >= 2 * W) begin
        check("col_valid", {31'd0, col_valid}, 32'd1);
        check("col_r", {8'd0, input_col_r}, exp_col(n, 0));
        check("col_g", {8'd0, input_col_g}, exp_col(n, 64));
        check("col_b", {8'd0, input_col_b}, exp_col(n, 128));
        check("window_done", {31'd0, window_done}, {31'd0, (n % W) >= 2});
        check("line_end", {31'd0, line_end}, {31'd0, (n % W) == W - 1});
        check("frame_done", {31'd0, frame_done}, {31'd0, n == W * H - 1});
      end else begin
        check("fill_no_col", {31'd0, col_valid}, 32'd0);
      end
      check("pix_ready", {31'd0, pix_ready}, {31'd0, n != W * H - 1});
      if (toggle && n >= 2 * W && n < 3 * W) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
        check("gap_col_valid", {31'd0, col_valid}, 32'd0);
        check("gap_window_done", {31'd0, window_done}, 32'd0);
        check("gap_line_end", {31'd0, line_end}, 32'd0);
        check("gap_col_r_hold", {8'd0, input_col_r}, exp_col(n, 0));
        check("gap_col_b_hold", {8'd0, input_col_b}, exp_col(n, 128));
      end
    end
    pix_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_pix_ready", {31'd0, pix_ready}, 32'd1);
    check("idle_col_valid", {31'd0, col_valid}, 32'd0);
    check("idle_frame_done", {31'd0, frame_done}, 32'd0);
    check("idle_col_r_hold", {8'd0, input_col_r}, exp_col(W * H - 1, 0));
  endtask

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    set_pix(0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_col_valid", {31'd0, col_valid}, 32'd0);
    check("rst_col_r", {8'd0, input_col_r}, 32'd0);
    check("rst_col_g", {8'd0, input_col_g}, 32'd0);
    check("rst_col_b", {8'd0, input_col_b}, 32'd0);
    check("rst_window_done", {31'd0, window_done}, 32'd0);
    check("rst_line_end", {31'd0, line_end}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_pix_ready", {31'd0, pix_ready}, 32'd1);

    run_frame(1'b0);
    run_frame(1'b1);

    // Partial frame up to pixel 8, then reset collides with pixel 9.
    for (int n = 0; n <= 2 * W; n++) begin
      set_pix(n);
      pix_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("pre_rst_col_r", {8'd0, input_col_r}, exp_col(2 * W, 0));
    set_pix(9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    pix_valid = 1'b0;
    check("midrst_col_valid", {31'd0, col_valid}, 32'd0);
    check("midrst_col_r", {8'd0, input_col_r}, 32'd0);
    check("midrst_pix_ready", {31'd0, pix_ready}, 32'd1);

    run_frame(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
